// File: rtl/mips_pkg.sv
// Shared pipeline constants used by the MEM/WB latch, the forwarding unit and writeback.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Bit positions inside the 2-bit WB control bundle {RegWrite, MemtoReg}.
  localparam int unsigned CTRL_WB_REGWRITE = 1;
  localparam int unsigned CTRL_WB_MEMTOREG = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_select.sv
// Writeback value mux and write-enable qualification.
module wb_select
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              rst,
  input  logic [1:0]        wb_control,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_write_en
);

  // Pick load data or ALU result; writes to r0 and writes during reset never commit.
  always_comb begin
    wb_write_data = wb_control[CTRL_WB_MEMTOREG] ? wb_read_data : wb_alu_result;
    wb_write_en   = wb_control[CTRL_WB_REGWRITE] && (wb_write_reg != ADDR_W'(REG_ZERO)) && !rst;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: commits the selected value into the register file, serves two bypassed
// ID read ports, a registered debug port and a committed-write counter.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = mips_pkg::NUM_REGS,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_control,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_write_en,
  output logic [CNT_W-1:0]  retire_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  wb_select #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wb_select (
    .rst           (rst),
    .wb_control    (wb_control),
    .wb_read_data  (wb_read_data),
    .wb_alu_result (wb_alu_result),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .wb_write_en   (wb_write_en)
  );

  // Same-cycle write-through so the ID stage never sees a stale WB value.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (rst || addr == ADDR_W'(REG_ZERO)) begin
      return '0;
    end else if (wb_write_en && wb_write_reg == addr) begin
      return wb_write_data;
    end else begin
      return regs[addr];
    end
  endfunction

  // Combinational ID read ports, resolved independently.
  always_comb begin
    rs_data = read_port(rs_addr);
    rt_data = read_port(rt_addr);
  end

  // Register commit, debug snapshot (pre-commit, no bypass) and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
      dbg_data     <= '0;
      retire_count <= '0;
    end else begin
      if (wb_write_en) begin
        regs[wb_write_reg] <= wb_write_data;
        retire_count       <= retire_count + CNT_W'(1);
      end
      dbg_data <= (dbg_addr == ADDR_W'(REG_ZERO)) ? '0 : regs[dbg_addr];
    end
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (load data or ALU result) and commits it into a 32x32 general-purpose register file.
- Provides two ID-stage read ports with same-cycle write-through bypass, so no WB-to-ID hazard exists.
- Also provides a debug read port and a committed-write counter for the bench and performance monitoring.

Parameters:
- DATA_W, 32, register and datapath width.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_control  input  2  {RegWrite, MemtoReg} from MEM/WB; bit1 RegWrite, bit0 MemtoReg.
- wb_read_data  input  DATA_W  latched data-memory read value.
- wb_alu_result  input  DATA_W  latched ALU result.
- wb_write_reg  input  ADDR_W  destination register index.
- rs_addr  input  ADDR_W  ID read port A index.
- rt_addr  input  ADDR_W  ID read port B index.
- rs_data  output  DATA_W  read port A data (combinational).
- rt_data  output  DATA_W  read port B data (combinational).
- dbg_addr  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  debug read data (registered, 1-cycle latency).
- wb_write_data  output  DATA_W  selected writeback value, driven to the forwarding unit.
- wb_write_en  output  1  write commits this cycle.
- retire_count  output  CNT_W  number of committed register writes.

Behaviour:
Writeback value and write enable (combinational):
- wb_write_data = MemtoReg ? wb_read_data : wb_alu_result.
- wb_write_en = RegWrite && (wb_write_reg != 0) && !rst.

Register commit:
- On the rising edge with wb_write_en=1, regs[wb_write_reg] <= wb_write_data.
- Register 0 is never written and always reads 0.

Read ports (combinational):
- If the address is 0, the port returns 0.
- Else if wb_write_en=1 and wb_write_reg equals the address, the port returns wb_write_data (write-through bypass, same cycle).
- Otherwise the port returns regs[address].
- Both ports may target the same register or the write register simultaneously; each port resolves independently.

Debug port:
- dbg_data <= value of regs[dbg_addr] as read before the same edge's commit; no bypass.
- Register 0 reads as 0.

Retire counter:
- retire_count increments by 1 on each edge where wb_write_en=1.
- It wraps modulo 2**CNT_W with no saturation.

Reset (rst=1 at an edge):
- All regs[1..NUM_REGS-1] <= 0, dbg_data <= 0, retire_count <= 0.
- While rst=1, wb_write_en=0, rs_data/rt_data are forced to 0, and no bypass is applied.
- A reset asserted mid-stream discards the pending write in that cycle; the register keeps its reset value of 0.

Other rules:
- No X propagation: every register has a defined value after the first reset edge.
- RegWrite=0 with any MemtoReg value produces no state change; wb_write_data is still driven.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS.
  - Control bit positions CTRL_WB_REGWRITE=1 and CTRL_WB_MEMTOREG=0.
  - REG_ZERO=5'd0.
- The same package is used by the MEM/WB latch and the forwarding unit.
- One natural sub-module, wb_select: the MemtoReg mux plus write-enable qualification.
- The register array, bypass and counter stay in wb_regfile.

Test Plan:
1. Reset, then read all 32 registers through rs/rt and the debug port -> every value 0, retire_count=0.
2. wb_control=2'b10, wb_alu_result=0x0000_1234, wb_write_reg=5; next cycle rs_addr=5 -> rs_data=0x0000_1234, retire_count=1.
3. wb_control=2'b11, wb_read_data=0xDEAD_BEEF, wb_alu_result=0x1111_1111, wb_write_reg=9, rs_addr=rt_addr=9 in the same cycle -> both ports return 0xDEAD_BEEF combinationally (bypass); dbg_addr=9 on the following cycle returns 0xDEAD_BEEF one cycle later.
4. wb_control=2'b10, wb_write_reg=0, data 0xFFFF_FFFF -> wb_write_en=0, rs_addr=0 reads 0, retire_count unchanged.
5. wb_control=2'b01, wb_write_reg=3, data 0xAAAA_AAAA -> no write; reg3 keeps its prior value 0.
6. Write 0x5555_5555 to reg7 with rst=1 in the same cycle -> reg7 reads 0 after reset, retire_count=0. Then preload retire_count to 2**CNT_W-1 via writes (or force in sim) plus one write -> counter wraps to 0.
